sync_fifo: RTL and testbench

Single-clock, parameterised first-in/first-out buffer with registered read data, full/empty flags and occupancy/free-space counters. It decouples a producer and a consumer running in the same clock domain inside the 8051 core, e.g. byte queues between the CPU bus and peripherals such as the serial port.

---
 rtl/sync_fifo_pkg.sv | 10 +
 rtl/sync_fifo_mem.sv | 38 +++
 rtl/sync_fifo.sv | 77 +++++++
 tb/tb_sync_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Default geometry shared by the FIFO top and its storage sub-module.
// Pure declarations: no logic, no latency, no flow control.
// Parameters of the instantiating module override these defaults.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_FIFO_DEPTH = 1 << DEF_ADDR_WIDTH;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port array: synchronous write port, synchronous enabled read port.
// Latency: read data registered, valid one cycle after the enabled edge.
// Backpressure: none here; the caller qualifies w_en/r_en against its flags.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (r_en) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty flags and level counters.
// Latency: written word readable next cycle; read data valid one cycle after accept.
// Backpressure: writes when full and reads when empty are silently dropped.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  is_empty,
    output logic                  is_full,
    output logic [ADDR_WIDTH:0]   data_avail,
    output logic [ADDR_WIDTH:0]   room_avail
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_ok;
    logic                  rd_ok;

    // Both sides qualify against this cycle's flags, so an empty FIFO never writes through.
    assign wr_ok = w_en && !is_full;
    assign rd_ok = r_en && !is_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign is_empty   = (count == '0);
    assign is_full    = (count == DEPTH_CNT);
    assign data_avail = count;
    assign room_avail = DEPTH_CNT - count;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .w_en   (wr_ok),
        .w_addr (wptr),
        .w_data (w_data),
        .r_en   (rd_ok),
        .r_addr (rptr),
        .r_data (r_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic          is_empty;
    logic          is_full;
    logic [AW:0]   data_avail;
    logic [AW:0]   room_avail;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_r;

    sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .w_en       (w_en),
        .w_data     (w_data),
        .r_en       (r_en),
        .r_data     (r_data),
        .is_empty   (is_empty),
        .is_full    (is_full),
        .data_avail (data_avail),
        .room_avail (room_avail)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        logic acc_w, acc_r;
        w_en   = w;
        w_data = d;
        r_en   = r;
        acc_w  = w && (q.size() < DEPTH);
        acc_r  = r && (q.size() != 0);
        @(posedge clk);
        if (acc_r) exp_r = q.pop_front();
        if (acc_w) q.push_back(d);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        q.delete();
        exp_r = '0;
        #2;
    endtask

    task automatic test_reset();
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b1, 8'h4D, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        pulse_reset();
        tests++;
        if (r_data !== 8'h00 || is_empty !== 1'b1 || is_full !== 1'b0 ||
            data_avail !== 5'd0 || room_avail !== 5'd16) begin
            fails++;
            $display("FAIL reset_async: r_data=%h empty=%b full=%b avail=%0d room=%0d, want 00 1 0 0 16",
                     r_data, is_empty, is_full, data_avail, room_avail);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0);
            tests++;
            if (data_avail !== 5'(q.size())) begin
                fails++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, data_avail, q.size());
            end
        end
        tests++;
        if (is_full !== 1'b1 || data_avail !== 5'd16 || room_avail !== 5'd0 || is_empty !== 1'b0) begin
            fails++;
            $display("FAIL fill_full: full=%b avail=%0d room=%0d empty=%b, want 1 16 0 0",
                     is_full, data_avail, room_avail, is_empty);
        end
        cycle(1'b1, 8'hFF, 1'b0);
        tests++;
        if (is_full !== 1'b1 || data_avail !== 5'd16 || room_avail !== 5'd0) begin
            fails++;
            $display("FAIL fill_overflow: full=%b avail=%0d room=%0d, want 1 16 0",
                     is_full, data_avail, room_avail);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            tests++;
            if (r_data !== exp_r || r_data !== DW'(i)) begin
                fails++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, r_data, DW'(i));
            end
        end
        tests++;
        if (is_empty !== 1'b1 || data_avail !== 5'd0 || room_avail !== 5'd16) begin
            fails++;
            $display("FAIL drain_empty: empty=%b avail=%0d room=%0d, want 1 0 16",
                     is_empty, data_avail, room_avail);
        end
        cycle(1'b0, 8'h00, 1'b1);
        tests++;
        if (r_data !== 8'h10 || data_avail !== 5'd0) begin
            fails++;
            $display("FAIL drain_underflow: r_data=%h avail=%0d, want 10 0", r_data, data_avail);
        end
    endtask

    task automatic test_wrap();
        int bad = 0;
        int n [4] = '{10, 10, 12, 12};
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < n[ph]; i++) begin
                if (ph % 2 == 0) cycle(1'b1, DW'($urandom), 1'b0);
                else begin
                    cycle(1'b0, 8'h00, 1'b1);
                    if (r_data !== exp_r) begin
                        bad++;
                        $display("FAIL wrap_data[%0d.%0d]: got %h want %h", ph, i, r_data, exp_r);
                    end
                end
            end
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (data_avail !== 5'd0 || is_empty !== 1'b1) begin
            fails++;
            $display("FAIL wrap_level: avail=%0d empty=%b, want 0 1", data_avail, is_empty);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        logic [DW-1:0] held;
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'($urandom), 1'b1);
            if (r_data !== exp_r || data_avail !== 5'd5) begin
                bad++;
                $display("FAIL b2b[%0d]: r_data=%h avail=%0d, want %h 5", i, r_data, data_avail, exp_r);
            end
        end
        tests++;
        if (bad != 0) fails++;
        for (int i = 0; i < 11; i++) cycle(1'b1, DW'($urandom), 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        tests++;
        if (data_avail !== 5'd15 || r_data !== exp_r || is_full !== 1'b0) begin
            fails++;
            $display("FAIL b2b_full: avail=%0d r_data=%h full=%b, want 15 %h 0",
                     data_avail, r_data, is_full, exp_r);
        end
        while (q.size() != 0) cycle(1'b0, 8'h00, 1'b1);
        held = exp_r;
        cycle(1'b1, 8'h77, 1'b1);
        tests++;
        if (data_avail !== 5'd1 || r_data !== held || is_empty !== 1'b0) begin
            fails++;
            $display("FAIL b2b_empty: avail=%0d r_data=%h empty=%b, want 1 %h 0",
                     data_avail, r_data, is_empty, held);
        end
        cycle(1'b0, 8'h00, 1'b1);
        tests++;
        if (r_data !== 8'h77) begin
            fails++;
            $display("FAIL b2b_empty_read: got %h want 77", r_data);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'($urandom), 1'b0);
        pulse_reset();
        tests++;
        if (data_avail !== 5'd0 || room_avail !== 5'd16 || is_empty !== 1'b1 || r_data !== 8'h00) begin
            fails++;
            $display("FAIL midreset_clear: avail=%0d room=%0d empty=%b r_data=%h, want 0 16 1 00",
                     data_avail, room_avail, is_empty, r_data);
        end
        rst = 1'b0;
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        tests++;
        if (r_data !== 8'hA5 || is_empty !== 1'b1) begin
            fails++;
            $display("FAIL midreset_read: r_data=%h empty=%b, want a5 1", r_data, is_empty);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 100) < 55, DW'($urandom), ($urandom % 100) < 45);
            if (r_data !== exp_r || data_avail !== 5'(q.size()) ||
                room_avail !== 5'(DEPTH - q.size()) ||
                is_empty !== (q.size() == 0) || is_full !== (q.size() == DEPTH)) begin
                bad++;
                $display("FAIL random[%0d]: r_data=%h avail=%0d room=%0d e=%b f=%b, want %h %0d",
                         i, r_data, data_avail, room_avail, is_empty, is_full, exp_r, q.size());
            end
        end
        tests++;
        if (bad != 0) fails++;
    endtask

    initial begin
        rst    = 1'b1;
        w_en   = 1'b0;
        r_en   = 1'b0;
        w_data = '0;
        exp_r  = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (is_empty !== 1'b1 || data_avail !== 5'd0 || room_avail !== 5'd16 || r_data !== 8'h00) begin
            fails++;
            $display("FAIL power_on_reset: empty=%b avail=%0d room=%0d r_data=%h", is_empty, data_avail,
                     room_avail, r_data);
        end
        rst = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
